// File: rtl/neuron_activation_layer_2.sv
// neuron_activation_layer_2: post-accumulation stage for layer 2.
// Adds the per-neuron bias to the adder-tree sum, rescales with a rounding arithmetic
// shift, applies optional ReLU, and saturates to OUT_WIDTH. Results are buffered in a
// small credit-protected FIFO toward the layer-3 input buffer.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_sum, in_bias       signed tree sum and bias, sampled on in_valid && in_ready
//   in_valid, in_ready    input handshake (in_ready depends on registers only)
//   relu_en               static per layer, 1 clamps negative results to zero
//   out_data, out_valid   registered FIFO head and non-empty flag
//   out_ready             consumer pops the head on out_valid && out_ready
//   sat_count             saturation events since reset, sticks at 0xFFFF
module neuron_activation_layer_2 #(
    parameter int unsigned IN_WIDTH   = 62,
    parameter int unsigned BIAS_WIDTH = 32,
    parameter int unsigned SHIFT      = 8,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [IN_WIDTH-1:0]   in_sum,
    input  logic signed [BIAS_WIDTH-1:0] in_bias,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         relu_en,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [15:0]                  sat_count
);
    localparam int unsigned S1_W  = IN_WIDTH + 1;
    localparam int unsigned EXT_W = S1_W + 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CRD_W = CNT_W + 1;

    localparam logic signed [EXT_W-1:0] ROUND   = $signed(EXT_W'(1) << (SHIFT - 1));
    localparam logic signed [EXT_W-1:0] SAT_MAX = $signed((EXT_W'(1) << (OUT_WIDTH - 1)) - EXT_W'(1));
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    logic                        accept;
    logic signed [S1_W-1:0]      s1;
    logic                        s1_valid;
    logic signed [EXT_W-1:0]     rnd, shr, rel;
    logic signed [OUT_WIDTH-1:0] act;
    logic                        act_sat;
    logic signed [OUT_WIDTH-1:0] s2_data;
    logic                        s2_sat;
    logic                        s2_valid;

    logic signed [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]            wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [CNT_W-1:0]            count, count_n;
    logic                        push, pop;
    logic signed [OUT_WIDTH-1:0] head_n;
    logic [CRD_W-1:0]            credit;

    assign accept = in_valid && in_ready;

    // Credit: everything already accepted (buffered or in flight) must fit in the FIFO.
    always_comb begin
        credit = CRD_W'(count) + CRD_W'(s1_valid) + CRD_W'(s2_valid);
    end
    assign in_ready = credit < CRD_W'(FIFO_DEPTH);

    // Stage 1: bias add, one bit of growth makes overflow impossible.
    always_ff @(posedge clk) begin
        if (accept) s1 <= S1_W'(in_sum) + S1_W'(in_bias);
    end

    // Stage 2 datapath: round half toward +inf, ReLU, then clip.
    always_comb begin
        rnd     = EXT_W'(s1) + ROUND;
        shr     = rnd >>> SHIFT;
        rel     = (relu_en && shr[EXT_W-1]) ? '0 : shr;
        act     = OUT_WIDTH'(rel);
        act_sat = 1'b0;
        if (rel > SAT_MAX) begin
            act     = OUT_WIDTH'(SAT_MAX);
            act_sat = 1'b1;
        end else if (rel < SAT_MIN) begin
            act     = OUT_WIDTH'(SAT_MIN);
            act_sat = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_valid) begin
            s2_data <= act;
            s2_sat  <= act_sat;
        end
    end

    // FIFO next state; the head register sees a same-edge push when it lands at the new read slot.
    always_comb begin
        push     = s2_valid;
        pop      = (count != '0) && out_ready;
        wr_ptr_n = push ? wr_ptr + PTR_W'(1) : wr_ptr;
        rd_ptr_n = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_n  = count;
        if (push && !pop)      count_n = count + CNT_W'(1);
        else if (!push && pop) count_n = count - CNT_W'(1);
        head_n = (push && (wr_ptr == rd_ptr_n)) ? s2_data : mem[rd_ptr_n];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s2_data;
    end

    // Control state: pipeline valids, FIFO pointers, head register and saturation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sat_count <= '0;
        end else begin
            s1_valid  <= accept;
            s2_valid  <= s1_valid;
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            count     <= count_n;
            out_valid <= (count_n != '0);
            if (count_n != '0) out_data <= head_n;
            if (push && s2_sat && (sat_count != 16'hFFFF)) sat_count <= sat_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_neuron_activation_layer_2.sv
// Self-checking bench for neuron_activation_layer_2: directed steps plus randomized
// streaming against an arithmetic reference model and an outstanding-entry queue.
module tb_neuron_activation_layer_2;
    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [61:0] in_sum;
    logic signed [31:0] in_bias;
    logic               in_valid;
    logic               in_ready;
    logic               relu_en;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        sat_count;

    neuron_activation_layer_2 dut (
        .clk(clk), .rst(rst), .in_sum(in_sum), .in_bias(in_bias), .in_valid(in_valid),
        .in_ready(in_ready), .relu_en(relu_en), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    longint q[$];
    longint exp_sat = 0;
    logic   relu = 1'b0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: bias add, floor((s + 128) / 256), ReLU, clip to 16-bit signed.
    function automatic longint ref_act(input longint s, input longint b, input logic r, output logic sat);
        longint t;
        t   = (s + b + 128) >>> 8;
        sat = 1'b0;
        if (r && t < 0) t = 0;
        if (t > 32767) begin t = 32767; sat = 1'b1; end
        else if (t < -32768) begin t = -32768; sat = 1'b1; end
        return t;
    endfunction

    // One clock: drive, check credit against outstanding count, capture handshakes, advance.
    task automatic cyc(input logic v, input longint s, input longint b, input logic ordy,
                       output logic acc, output logic rdy);
        logic   pop, sat;
        longint popped, e;
        in_valid = v; in_sum = 62'(s); in_bias = 32'(b); out_ready = ordy; relu_en = relu;
        #1;
        chk("in_ready_credit", in_ready, (q.size() < DEPTH));
        if (q.size() == 0) chk("no_stale_out_valid", out_valid, 0);
        rdy    = in_ready;
        acc    = v && in_ready;
        pop    = out_valid && ordy;
        popped = longint'(out_data);
        @(posedge clk);
        #1;
        if (pop) begin
            if (q.size() == 0) chk("pop_with_nothing_outstanding", 1, 0);
            else chk("out_data_order", popped, q.pop_front());
        end
        if (acc) begin
            e = ref_act(s, b, relu, sat);
            q.push_back(e);
            if (sat) exp_sat++;
        end
    endtask

    task automatic idle(input logic ordy);
        logic a, r;
        cyc(1'b0, 0, 0, ordy, a, r);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) idle(1'b1);
        chk("drain_complete", q.size(), 0);
        idle(1'b1);
        chk("sat_count_model", sat_count, (exp_sat > 65535) ? 65535 : exp_sat);
    endtask

    function automatic longint rnd_sum();
        longint r;
        r = longint'({$urandom, $urandom});
        return r >>> (2 + $urandom_range(0, 50));
    endfunction

    initial begin
        logic a, r;
        int   n;
        rst = 1'b1; in_valid = 0; in_sum = '0; in_bias = '0; out_ready = 0; relu_en = 0;
        #12 rst = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_sat_count", sat_count, 0);

        // Rounding and bias with latency check.
        relu = 1'b0;
        cyc(1, 1000, 24, 0, a, r);
        chk("accept_first", a, 1);
        idle(0);
        chk("latency_not_yet", out_valid, 0);
        idle(0);
        chk("latency_valid", out_valid, 1);
        chk("round_bias", out_data, 4);
        drain();
        cyc(1, -1000000, 0, 0, a, r);
        idle(0); idle(0);
        chk("round_neg_valid", out_valid, 1);
        chk("round_neg", out_data, -3906);
        drain();

        // ReLU clamp is not a saturation event.
        relu = 1'b1;
        cyc(1, -500, 0, 0, a, r);
        idle(0); idle(0);
        chk("relu_clamp", out_data, 0);
        drain();
        chk("relu_no_sat", sat_count, 0);
        cyc(1, 2560, 0, 0, a, r);
        idle(0); idle(0);
        chk("relu_pass", out_data, 10);
        drain();

        // Saturation both directions.
        relu = 1'b0;
        cyc(1, 64'sd1 <<< 30, 0, 0, a, r);
        cyc(1, -(64'sd1 <<< 30), 0, 0, a, r);
        idle(0);
        chk("sat_pos", out_data, 32767);
        idle(0);
        chk("sat_head_held", out_data, 32767);
        drain();
        chk("sat_count_two", sat_count, 2);

        // Backpressure: exactly DEPTH accepts, in_ready low from the fifth cycle.
        n = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, rnd_sum(), longint'(int'($urandom)), 0, a, r);
            if (a) n++;
            if (i >= 4) chk("bp_in_ready_low", r, 0);
        end
        chk("bp_accept_count", n, 4);
        idle(1);
        chk("bp_ready_after_pop", in_ready, 1);
        drain();

        // Random streaming with random out_ready.
        relu = $urandom_range(0, 1);
        n = 0;
        for (int i = 0; i < 2000 && n < 100; i++) begin
            cyc(1, rnd_sum(), longint'(int'($urandom)), $urandom_range(0, 1), a, r);
            if (a) n++;
        end
        chk("stream_accepts", n, 100);
        drain();

        // Reset with 2 buffered and 2 in flight.
        relu = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1, (i % 2 == 0) ? (64'sd1 <<< 40) : -(64'sd1 <<< 40), 0, 0, a, r);
        chk("pre_reset_sat_nonzero", sat_count != 0, 1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_sat_count", sat_count, 0);
        q.delete();
        exp_sat = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) idle(1);
        cyc(1, 2560, 0, 0, a, r);
        idle(0); idle(0);
        chk("post_reset_data", out_data, 10);
        drain();

        // Saturation counter sticks at 0xFFFF.
        for (int i = 0; i < 65540; i++) cyc(1, (i % 2 == 0) ? (64'sd1 <<< 30) : -(64'sd1 <<< 30), 5, 1, a, r);
        drain();
        chk("sat_count_sticky", sat_count, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
